// File: rtl/fp_mac_pkg.sv
// ============================================================================
// fp_mac_pkg : shared class bits, flag indices and rounding modes for the MAC
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_mac_pkg;

  localparam int TYPE_W         = 6;
  localparam int TYPE_ZERO      = 0;
  localparam int TYPE_INF       = 1;
  localparam int TYPE_QNAN      = 2;
  localparam int TYPE_SNAN      = 3;
  localparam int TYPE_SUBNORMAL = 4;
  localparam int TYPE_NORMAL    = 5;

  localparam int FLAG_W         = 3;
  localparam int FLAG_OVERFLOW  = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 2;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rmode_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_pack_round_if.sv
// ============================================================================
// fp_pack_round_if : input beat / output beat channels of the result packer
// Rev 1.0
// ============================================================================
`default_nettype none

interface fp_pack_round_if
  import fp_mac_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int XTR_W = 3
);
  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = 1 + MAN_W + XTR_W;

  logic                      IN_VALID;
  logic                      IN_READY;
  logic [TYPE_W-1:0]         EXTR_TYPE;
  logic [WORD_W-1:0]         EXTR_DATA;
  rmode_e                    RMODE;
  logic                      SIGN;
  logic signed [EXP_W+1:0]   EXPONENT;
  logic [SIG_W-1:0]          SIGNIFICAND;
  logic                      OUT_VALID;
  logic                      OUT_READY;
  logic [TYPE_W-1:0]         P_TYPE;
  logic [WORD_W-1:0]         P;
  logic [FLAG_W-1:0]         FLAGS;

  modport master (
    output IN_VALID, EXTR_TYPE, EXTR_DATA, RMODE, SIGN, EXPONENT, SIGNIFICAND, OUT_READY,
    input  IN_READY, OUT_VALID, P_TYPE, P, FLAGS
  );

  modport slave (
    input  IN_VALID, EXTR_TYPE, EXTR_DATA, RMODE, SIGN, EXPONENT, SIGNIFICAND, OUT_READY,
    output IN_READY, OUT_VALID, P_TYPE, P, FLAGS
  );

endinterface

`default_nettype wire

// File: rtl/sticky_rshift.sv
// ============================================================================
// sticky_rshift : logical right shift that ORs every lost bit into a sticky bit
// Rev 1.0
// ============================================================================
`default_nettype none

module sticky_rshift #(
  parameter int W    = 14,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    data_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    data_o,
  output logic            sticky_o
);

  always_comb begin
    data_o   = '0;
    sticky_o = |data_i;
    if (32'(shamt_i) < 32'(W)) begin
      data_o   = data_i >> shamt_i;
      sticky_o = |(data_i & ~({W{1'b1}} << shamt_i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_pack_round.sv
// ============================================================================
// fp_pack_round : two-stage denormalise / round / saturate / classify packer
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_pack_round
  import fp_mac_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int XTR_W = 3
) (
  input  logic           CLK,
  input  logic           RST,
  fp_pack_round_if.slave bus
);

  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = 1 + MAN_W + XTR_W;
  localparam int E_W    = EXP_W + 3;
  localparam int X_W    = EXP_W + 2;

  localparam logic signed [E_W-1:0] BIAS_E   = E_W'(bias(EXP_W));
  localparam logic signed [E_W-1:0] ONE_E    = E_W'(1);
  localparam logic [X_W-1:0]        EXP_SAT  = X_W'((1 << EXP_W) - 1);
  localparam logic [SIG_W-1:0]      LOW_MASK = SIG_W'((1 << (XTR_W - 1)) - 1);

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s2_ready, in_ready;

  assign s2_ready = !s2_valid_q || bus.OUT_READY;
  assign in_ready = !s1_valid_q || s2_ready;

  // ---------------- stage S1: bias and denormalise ----------------
  logic signed [E_W-1:0] exp_ext, e_biased;
  logic                  tiny;
  logic [E_W-1:0]        shamt;
  logic [SIG_W-1:0]      sig_shifted;
  logic                  shift_sticky;
  logic [X_W-1:0]        eff_e_d;

  assign exp_ext  = {bus.EXPONENT[EXP_W+1], bus.EXPONENT};
  assign e_biased = exp_ext + BIAS_E;
  assign tiny     = e_biased[E_W-1] || (e_biased == '0);
  assign shamt    = tiny ? (ONE_E - e_biased) : '0;
  assign eff_e_d  = tiny ? '0 : e_biased[X_W-1:0];

  sticky_rshift #(
    .W   (SIG_W),
    .SH_W(E_W)
  ) u_sticky_rshift (
    .data_i  (bus.SIGNIFICAND),
    .shamt_i (shamt),
    .data_o  (sig_shifted),
    .sticky_o(shift_sticky)
  );

  logic               s1_special_q;
  logic [TYPE_W-1:0]  s1_type_q;
  logic [WORD_W-1:0]  s1_data_q;
  rmode_e             s1_rmode_q;
  logic               s1_sign_q;
  logic [X_W-1:0]     s1_exp_q;
  logic [SIG_W-1:0]   s1_sig_q;
  logic               s1_sticky_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q   <= 1'b0;
      s1_special_q <= 1'b0;
      s1_type_q    <= '0;
      s1_data_q    <= '0;
      s1_rmode_q   <= RM_RNE;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_sig_q     <= '0;
      s1_sticky_q  <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        s1_special_q <= |bus.EXTR_TYPE[TYPE_SNAN:TYPE_ZERO];
        s1_type_q    <= bus.EXTR_TYPE;
        s1_data_q    <= bus.EXTR_DATA;
        s1_rmode_q   <= bus.RMODE;
        s1_sign_q    <= bus.SIGN;
        s1_exp_q     <= eff_e_d;
        s1_sig_q     <= sig_shifted;
        s1_sticky_q  <= shift_sticky;
      end
    end
  end

  // ---------------- stage S2: round, saturate, classify ----------------
  logic [MAN_W:0]   mant;
  logic             guard, sticky, inexact, inc, overflow;
  logic [MAN_W+1:0] rounded;
  logic [X_W-1:0]   exp_r;
  logic [MAN_W-1:0] frac;

  assign mant     = s1_sig_q[SIG_W-1:XTR_W];
  assign guard    = s1_sig_q[XTR_W-1];
  assign sticky   = s1_sticky_q || (|(s1_sig_q & LOW_MASK));
  assign inexact  = guard || sticky;
  assign inc      = (s1_rmode_q == RM_RNE) && guard && (sticky || mant[0]);
  assign rounded  = {1'b0, mant} + (MAN_W + 2)'(inc);
  // Carry into the hidden bit promotes a subnormal to min-normal; carry past it bumps the binade.
  assign exp_r    = s1_exp_q + X_W'(rounded[MAN_W+1])
                  + X_W'((s1_exp_q == '0) && rounded[MAN_W]);
  assign frac     = rounded[MAN_W-1:0];
  assign overflow = (exp_r >= EXP_SAT);

  logic [WORD_W-1:0] p_d, p_q;
  logic [TYPE_W-1:0] p_type_d, p_type_q;
  logic [FLAG_W-1:0] flags_d, flags_q;

  always_comb begin
    p_d      = '0;
    p_type_d = '0;
    flags_d  = '0;
    if (s1_special_q) begin
      p_d      = s1_data_q;
      p_type_d = s1_type_q;
    end else if (overflow) begin
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
      if (s1_rmode_q == RM_RNE) begin
        p_d                = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        p_type_d[TYPE_INF] = 1'b1;
      end else begin
        p_d                   = {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        p_type_d[TYPE_NORMAL] = 1'b1;
      end
    end else begin
      p_d                   = {s1_sign_q, exp_r[EXP_W-1:0], frac};
      flags_d[FLAG_INEXACT] = inexact;
      if (exp_r == '0) begin
        flags_d[FLAG_UNDERFLOW] = inexact;
        if (frac == '0) p_type_d[TYPE_ZERO]      = 1'b1;
        else            p_type_d[TYPE_SUBNORMAL] = 1'b1;
      end else begin
        p_type_d[TYPE_NORMAL] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      p_q        <= '0;
      p_type_q   <= '0;
      flags_q    <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        p_q      <= p_d;
        p_type_q <= p_type_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = s2_valid_q;
  assign bus.P         = p_q;
  assign bus.P_TYPE    = p_type_q;
  assign bus.FLAGS     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_pack_round.sv
// ============================================================================
// tb_fp_pack_round : directed fp16 vectors for the result packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_pack_round;
  import fp_mac_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] got_p;
  logic [5:0]  got_type;
  logic [2:0]  got_flags;
  int          got_lat;

  fp_pack_round_if #(.EXP_W(5), .MAN_W(10), .XTR_W(3)) bus ();

  fp_pack_round #(.EXP_W(5), .MAN_W(10), .XTR_W(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_beat(input logic [5:0] typ, input logic [15:0] xd, input rmode_e rm,
                          input logic sg, input logic signed [6:0] ex, input logic [13:0] sig);
    bus.EXTR_TYPE   = typ;
    bus.EXTR_DATA   = xd;
    bus.RMODE       = rm;
    bus.SIGN        = sg;
    bus.EXPONENT    = ex;
    bus.SIGNIFICAND = sig;
  endtask

  // Sends one beat into an idle pipeline and captures the result beat.
  task automatic send_one(input logic [5:0] typ, input logic [15:0] xd, input rmode_e rm,
                          input logic sg, input logic signed [6:0] ex, input logic [13:0] sig);
    logic acc, rdy, seen;
    acc = 1'b0; seen = 1'b0;
    got_p = 'x; got_type = 'x; got_flags = 'x; got_lat = 0;
    @(negedge CLK);
    set_beat(typ, xd, rm, sg, ex, sig);
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1 rdy = bus.IN_READY;
      @(posedge CLK);
      if (rdy) acc = 1'b1;
    end
    #1 bus.IN_VALID = 1'b0;
    got_lat = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.OUT_VALID) begin
        seen = 1'b1; got_p = bus.P; got_type = bus.P_TYPE; got_flags = bus.FLAGS;
      end else begin
        @(posedge CLK);
        got_lat++;
      end
    end
    if (!acc || !seen) begin
      errors++;
      $display("FAIL send_timeout: accepted=%0b output_seen=%0b", acc, seen);
    end
  endtask

  task automatic test_reset;
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    set_beat(6'b0, 16'h0, RM_RNE, 1'b0, 7'sd0, 14'h0);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.OUT_VALID); end
    checks++; if (bus.P !== 16'h0000) begin errors++; $display("FAIL reset_p: got %h want 0000", bus.P); end
    checks++; if (bus.P_TYPE !== 6'b0) begin errors++; $display("FAIL reset_p_type: got %b want 000000", bus.P_TYPE); end
    checks++; if (bus.FLAGS !== 3'b0) begin errors++; $display("FAIL reset_flags: got %b want 000", bus.FLAGS); end
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.IN_READY); end
  endtask

  task automatic test_normal;
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, 7'sd0, 14'h2000);
    checks++; if (got_p !== 16'h3C00) begin errors++; $display("FAIL one_p: got %h want 3c00", got_p); end
    checks++; if (got_type !== 6'b100000) begin errors++; $display("FAIL one_type: got %b want 100000", got_type); end
    checks++; if (got_flags !== 3'b000) begin errors++; $display("FAIL one_flags: got %b want 000", got_flags); end
    checks++; if (got_lat !== 2) begin errors++; $display("FAIL one_latency: got %0d want 2", got_lat); end
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, -7'sd14, 14'h2000);
    checks++; if (got_p !== 16'h0400) begin errors++; $display("FAIL min_normal_p: got %h want 0400", got_p); end
    checks++; if (got_type !== 6'b100000) begin errors++; $display("FAIL min_normal_type: got %b want 100000", got_type); end
  endtask

  task automatic test_subnormal;
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, -7'sd24, 14'h2000);
    checks++; if (got_p !== 16'h0001) begin errors++; $display("FAIL sub_min_p: got %h want 0001", got_p); end
    checks++; if (got_type !== 6'b010000) begin errors++; $display("FAIL sub_min_type: got %b want 010000", got_type); end
    checks++; if (got_flags !== 3'b000) begin errors++; $display("FAIL sub_min_flags: got %b want 000", got_flags); end
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, -7'sd15, 14'h2000);
    checks++; if (got_p !== 16'h0200) begin errors++; $display("FAIL sub_half_p: got %h want 0200", got_p); end
    checks++; if (got_type !== 6'b010000) begin errors++; $display("FAIL sub_half_type: got %b want 010000", got_type); end
  endtask

  task automatic test_underflow_round;
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, -7'sd25, 14'h2000);
    checks++; if (got_p !== 16'h0000) begin errors++; $display("FAIL tie_even_p: got %h want 0000", got_p); end
    checks++; if (got_type !== 6'b000001) begin errors++; $display("FAIL tie_even_type: got %b want 000001", got_type); end
    checks++; if (got_flags !== 3'b110) begin errors++; $display("FAIL tie_even_flags: got %b want 110", got_flags); end
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, -7'sd25, 14'h2008);
    checks++; if (got_p !== 16'h0001) begin errors++; $display("FAIL sticky_up_p: got %h want 0001", got_p); end
    checks++; if (got_type !== 6'b010000) begin errors++; $display("FAIL sticky_up_type: got %b want 010000", got_type); end
    checks++; if (got_flags !== 3'b110) begin errors++; $display("FAIL sticky_up_flags: got %b want 110", got_flags); end
  endtask

  task automatic test_overflow;
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, 7'sd16, 14'h2000);
    checks++; if (got_p !== 16'h7C00) begin errors++; $display("FAIL ovf_rne_p: got %h want 7c00", got_p); end
    checks++; if (got_type !== 6'b000010) begin errors++; $display("FAIL ovf_rne_type: got %b want 000010", got_type); end
    checks++; if (got_flags !== 3'b101) begin errors++; $display("FAIL ovf_rne_flags: got %b want 101", got_flags); end
    send_one(6'b100000, 16'h0, RM_RTZ, 1'b0, 7'sd16, 14'h2000);
    checks++; if (got_p !== 16'h7BFF) begin errors++; $display("FAIL ovf_rtz_p: got %h want 7bff", got_p); end
    checks++; if (got_type !== 6'b100000) begin errors++; $display("FAIL ovf_rtz_type: got %b want 100000", got_type); end
    checks++; if (got_flags !== 3'b101) begin errors++; $display("FAIL ovf_rtz_flags: got %b want 101", got_flags); end
    send_one(6'b100000, 16'h0, RM_RNE, 1'b1, 7'sd16, 14'h2000);
    checks++; if (got_p !== 16'hFC00) begin errors++; $display("FAIL ovf_neg_p: got %h want fc00", got_p); end
  endtask

  task automatic test_carry;
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, 7'sd0, 14'h3FFC);
    checks++; if (got_p !== 16'h4000) begin errors++; $display("FAIL carry_p: got %h want 4000", got_p); end
    checks++; if (got_type !== 6'b100000) begin errors++; $display("FAIL carry_type: got %b want 100000", got_type); end
    checks++; if (got_flags !== 3'b100) begin errors++; $display("FAIL carry_flags: got %b want 100", got_flags); end
    send_one(6'b100000, 16'h0, RM_RTZ, 1'b0, 7'sd0, 14'h3FFC);
    checks++; if (got_p !== 16'h3FFF) begin errors++; $display("FAIL rtz_trunc_p: got %h want 3fff", got_p); end
    checks++; if (got_flags !== 3'b100) begin errors++; $display("FAIL rtz_trunc_flags: got %b want 100", got_flags); end
  endtask

  task automatic test_special;
    send_one(6'b000100, 16'h7E00, RM_RNE, 1'b0, 7'sd16, 14'h3FFF);
    checks++; if (got_p !== 16'h7E00) begin errors++; $display("FAIL special_p: got %h want 7e00", got_p); end
    checks++; if (got_type !== 6'b000100) begin errors++; $display("FAIL special_type: got %b want 000100", got_type); end
    checks++; if (got_flags !== 3'b000) begin errors++; $display("FAIL special_flags: got %b want 000", got_flags); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_p [4];
    logic [15:0] outs  [8];
    logic fire_in, fire_out;
    int sent, nout;
    exp_p[0] = 16'h3C00; exp_p[1] = 16'h4000; exp_p[2] = 16'h4400; exp_p[3] = 16'h4800;
    sent = 0; nout = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (c == 5) begin
        checks++; if (sent !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", sent); end
        checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.IN_READY); end
        checks++; if (bus.OUT_VALID !== 1'b1 || bus.P !== 16'h3C00) begin
          errors++; $display("FAIL bp_held: got valid=%b p=%h want valid=1 p=3c00", bus.OUT_VALID, bus.P);
        end
      end
      bus.OUT_READY = (c >= 5);
      if (sent < 4) begin
        set_beat(6'b100000, 16'h0, RM_RNE, 1'b0, 7'(sent), 14'h2000);
        bus.IN_VALID = 1'b1;
      end else begin
        bus.IN_VALID = 1'b0;
      end
      #1;
      fire_in  = bus.IN_VALID && bus.IN_READY;
      fire_out = bus.OUT_VALID && bus.OUT_READY;
      if (fire_out) begin
        if (nout < 8) outs[nout] = bus.P;
        nout++;
      end
      @(posedge CLK);
      if (fire_in) sent++;
    end
    checks++; if (nout !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", nout); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= nout || outs[i] !== exp_p[i]) begin
        errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, (i < nout) ? outs[i] : 16'hxxxx, exp_p[i]);
      end
    end
  endtask

  task automatic test_reset_flush;
    int stale;
    stale = 0;
    @(negedge CLK);
    bus.OUT_READY = 1'b0;
    for (int b = 0; b < 2; b++) begin
      set_beat(6'b100000, 16'h0, RM_RNE, 1'b0, 7'(4 + b), 14'h2000);
      bus.IN_VALID = 1'b1;
      @(negedge CLK);
    end
    bus.IN_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.OUT_VALID); end
    RST = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.OUT_VALID) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale: got %0d beats want 0", stale); end
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.IN_READY); end
    send_one(6'b100000, 16'h0, RM_RNE, 1'b0, 7'sd1, 14'h2000);
    checks++; if (got_p !== 16'h4000) begin errors++; $display("FAIL flush_after_p: got %h want 4000", got_p); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_underflow_round();
    test_overflow();
    test_carry();
    test_special();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
